// File: rtl/inst_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
// Field widths are derived from the line count so every file agrees on the address split.
package inst_cache_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int OFFSET_BITS = 3;  // two 32-bit words per line

    typedef enum logic [1:0] {
        IDLE,
        FILL0,
        FILL1
    } state_t;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines);
        return ADDR_W - OFFSET_BITS - $clog2(lines);
    endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Tag/data storage for the instruction cache: one combinational read port,
// one whole-line write port, and a valid vector with a single-cycle clear-all.
module inst_cache_array
    import inst_cache_pkg::*;
#(
    parameter int LINES = 32,
    localparam int IDX_W = idx_width(LINES),
    localparam int TAG_W = tag_width(LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data0,
    output logic [WORD_W-1:0] rd_data1,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data0,
    input  logic [WORD_W-1:0] wr_data1,
    input  logic              clear_all
);

    logic [TAG_W-1:0]  tag_mem   [LINES];
    logic [WORD_W-1:0] data0_mem [LINES];
    logic [WORD_W-1:0] data1_mem [LINES];
    logic [LINES-1:0]  valid_bits;

    // NOTE: tag/data arrays are deliberately left out of reset; only the valid
    // bits need a known value, and that keeps the arrays mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]   <= wr_tag;
            data0_mem[wr_idx] <= wr_data0;
            data1_mem[wr_idx] <= wr_data1;
        end
    end

    // Clear-all wins over a same-edge line write so a pending flush also drops the new line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_bits <= '0;
        end else if (clear_all) begin
            valid_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_idx] <= 1'b1;
        end
    end

    assign rd_valid = valid_bits[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data0 = data0_mem[rd_idx];
    assign rd_data1 = data1_mem[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, and a two-beat
// req/ack refill from instruction memory that freezes the fetch stage on a miss.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int LINES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              flush,
    output logic [WORD_W-1:0] inst,
    output logic              cache_freeze,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int IDX_W  = idx_width(LINES);
    localparam int TAG_W  = tag_width(LINES);
    localparam int LINE_W = TAG_W + IDX_W;

    logic              offset;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              unused_pc_bits;

    assign offset         = pc[2];
    assign idx            = pc[2+IDX_W:3];
    assign tag            = pc[ADDR_W-1:3+IDX_W];
    assign unused_pc_bits = ^pc[1:0];

    state_t            state, state_n;
    logic              mem_req_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [LINE_W-1:0] miss_line, miss_line_n;
    logic [WORD_W-1:0] fill_buf, fill_buf_n;
    logic              flush_pend, flush_pend_n;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_data0, rd_data1;
    logic              wr_en;
    logic              clear_all;
    logic              hit, miss;

    inst_cache_array #(
        .LINES (LINES)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data0  (rd_data0),
        .rd_data1  (rd_data1),
        .wr_en     (wr_en),
        .wr_idx    (miss_line[IDX_W-1:0]),
        .wr_tag    (miss_line[LINE_W-1:IDX_W]),
        .wr_data0  (fill_buf),
        .wr_data1  (mem_rdata),
        .clear_all (clear_all)
    );

    assign hit          = pc_valid & rd_valid & (rd_tag == tag);
    assign miss         = pc_valid & ~hit;
    assign inst         = offset ? rd_data1 : rd_data0;
    assign cache_freeze = (state != IDLE) | ((state == IDLE) & miss);

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            miss_line  <= '0;
            fill_buf   <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_n;
            mem_req    <= mem_req_n;
            mem_addr   <= mem_addr_n;
            miss_line  <= miss_line_n;
            fill_buf   <= fill_buf_n;
            flush_pend <= flush_pend_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        mem_req_n    = mem_req;
        mem_addr_n   = mem_addr;
        miss_line_n  = miss_line;
        fill_buf_n   = fill_buf;
        flush_pend_n = flush_pend;
        wr_en        = 1'b0;
        clear_all    = 1'b0;

        unique case (state)
            IDLE: begin
                clear_all = flush;
                if (miss) begin
                    miss_line_n = {tag, idx};
                    mem_addr_n  = {tag, idx, 3'b000};
                    mem_req_n   = 1'b1;
                    state_n     = FILL0;
                end
            end
            FILL0: begin
                if (flush) flush_pend_n = 1'b1;
                if (mem_ack) begin
                    fill_buf_n = mem_rdata;
                    mem_addr_n = {miss_line, 3'b100};
                    state_n    = FILL1;
                end
            end
            FILL1: begin
                if (flush) flush_pend_n = 1'b1;
                if (mem_ack) begin
                    // A flush seen during the fill invalidates everything, the new line included.
                    wr_en        = 1'b1;
                    clear_all    = flush_pend | flush;
                    flush_pend_n = 1'b0;
                    mem_req_n    = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: a line-level cache model predicts hit/miss,
// refill addresses and freeze length; a monitor and a memory responder check the DUT.
module tb_inst_cache;

    localparam int LINES = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [31:0] inst;
    logic        cache_freeze;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    inst_cache #(
        .LINES (LINES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .inst         (inst),
        .cache_freeze (cache_freeze),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        int          freeze;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] addr_q[$];
    int          dly_q[$];

    bit          valid_m [LINES];
    logic [23:0] tag_m   [LINES];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic void model_clear();
        foreach (valid_m[i]) valid_m[i] = 1'b0;
    endfunction

    task automatic push_fill(input logic [31:0] a, input int w0, input int w1);
        addr_q.push_back({a[31:3], 3'b000});
        addr_q.push_back({a[31:3], 3'b100});
        dly_q.push_back(w0);
        dly_q.push_back(w1);
    endtask

    // One fetch at address a; runs until the DUT presents it unfrozen.
    task automatic lookup(input logic [31:0] a, input bit idle_flush, input bit mid_flush,
                          input int d0, input int d1, input int e0, input int e1);
        int    li;
        bit    hit;
        bit    mf;
        int    fz;
        resp_t r;
        li  = int'(a[7:3]);
        hit = valid_m[li] && (tag_m[li] == a[31:8]);
        if (idle_flush) model_clear();
        mf = mid_flush && !hit;
        fz = 0;
        if (!hit) begin
            push_fill(a, d0, d1);
            fz = 3 + d0 + d1;
            valid_m[li] = 1'b1;
            tag_m[li]   = a[31:8];
            if (mf) begin
                model_clear();
                push_fill(a, e0, e1);
                fz += 3 + e0 + e1;
                valid_m[li] = 1'b1;
            end
        end
        r.inst   = mem_word({a[31:2], 2'b00});
        r.freeze = fz;
        exp_q.push_back(r);

        @(posedge clk); #1;
        pc       = a;
        pc_valid = 1'b1;
        flush    = idle_flush;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (!cache_freeze) break;
            if (k >= 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL lookup_timeout: pc 0x%08h still frozen after %0d cycles", a, k);
                break;
            end
            @(posedge clk); #1;
            flush = (k == 0) && mf;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pc_valid = 1'b0;
            flush    = 1'b0;
            pc       = $urandom;
        end
    endtask

    // Reset lands in FILL1 while the second word is still outstanding.
    task automatic reset_mid_fill(input logic [31:0] a);
        @(posedge clk); #1;
        push_fill(a, 0, 3);
        pc       = a;
        pc_valid = 1'b1;
        flush    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("fill1_mem_req", {31'd0, mem_req}, 32'd1);
        check("fill1_mem_addr", mem_addr, {a[31:3], 3'b100});
        rst      = 1'b1;
        pc_valid = 1'b0;
        #1;
        check("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'd0);
        check("rst_mid_freeze", {31'd0, cache_freeze}, 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        model_clear();
    endtask

    // Monitor: counts frozen cycles and compares each presented instruction.
    initial begin
        int    cnt;
        resp_t r;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
            end else if (pc_valid) begin
                if (cache_freeze) begin
                    cnt++;
                end else begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: inst 0x%08h with empty scoreboard", inst);
                    end else begin
                        r = exp_q.pop_front();
                        check("inst", inst, r.inst);
                        check("freeze_cycles", cnt, r.freeze);
                    end
                    cnt = 0;
                end
            end else begin
                check("idle_freeze", {31'd0, cache_freeze}, 32'd0);
                check("idle_mem_req", {31'd0, mem_req}, 32'd0);
            end
        end
    end

    // Memory responder: acks each request after the scheduled delay, checks addresses,
    // and throws stray acks while no request is outstanding.
    initial begin
        int          d;
        bit          have;
        logic [31:0] cur;
        d         = 0;
        have      = 1'b0;
        cur       = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (rst || !mem_req) begin
                have = 1'b0;
                if (!rst) mem_ack = ($urandom_range(0, 3) == 0);
            end else begin
                if (!have) begin
                    have = 1'b1;
                    cur  = mem_addr;
                    if (addr_q.size() != 0) begin
                        check("refill_addr", mem_addr, addr_q.pop_front());
                    end else begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_req: mem_addr 0x%08h", mem_addr);
                    end
                    d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
                end
                if (d == 0) begin
                    check("refill_addr_stable", mem_addr, cur);
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    have      = 1'b0;
                end else begin
                    d--;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ifl, mfl;
        rst      = 1'b1;
        pc       = 32'h0;
        pc_valid = 1'b1;
        flush    = 1'b0;
        model_clear();
        #12;
        check("reset_freeze_valid", {31'd0, cache_freeze}, 32'd1);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        pc_valid = 1'b0;
        #1;
        check("reset_freeze_idle", {31'd0, cache_freeze}, 32'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        idle_cycles(4);

        lookup(32'h0000_0000, 0, 0, 0, 0, 0, 0);   // cold miss
        lookup(32'h0000_0004, 0, 0, 0, 0, 0, 0);   // same line hit
        lookup(32'h0000_0100, 0, 0, 0, 0, 0, 0);   // conflict on index 0
        lookup(32'h0000_0000, 0, 0, 1, 2, 0, 0);   // evicted line misses again
        lookup(32'h0000_03C8, 0, 0, 5, 5, 0, 0);   // slow memory
        lookup(32'h0000_03CC, 0, 0, 0, 0, 0, 0);
        lookup(32'h0000_0020, 0, 1, 0, 0, 0, 0);   // flush during FILL0
        lookup(32'h0000_0024, 0, 0, 0, 0, 0, 0);
        lookup(32'h0000_0004, 1, 0, 0, 0, 0, 0);   // flush in IDLE on a hit
        lookup(32'h0000_0024, 0, 0, 0, 0, 0, 0);   // flushed line misses
        idle_cycles(6);
        lookup(32'h0000_0000, 0, 0, 0, 0, 0, 0);
        reset_mid_fill(32'h0000_0040);
        idle_cycles(3);
        lookup(32'h0000_0000, 0, 0, 0, 0, 0, 0);   // lost after reset
        lookup(32'h0000_0040, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 400; t++) begin
            ifl = ($urandom_range(0, 19) == 0);
            mfl = !ifl && ($urandom_range(0, 9) == 0);
            lookup({21'd0, 9'($urandom_range(0, 511)), 2'b00}, ifl, mfl,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(4);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("refill_queue_drained", addr_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache that answers the fetch stage's PC lookups and refills lines from backing instruction memory over a req/ack handshake. It sits between the fetch stage's PC register and the external instruction memory. A hit returns the instruction combinationally in the same cycle. A miss asserts `cache_freeze`, which holds the PC register until the line is filled.

## Interface
Parameters:
- `LINES`, default 32: number of cache lines; power of two, at least 2. `IDX_W = log2(LINES)`.
- `WORDS_PER_LINE`: fixed at 2 (not a parameter). Each line holds two 32-bit words.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `pc`, input, 32: fetch byte address. Bits [1:0] are ignored.
- `pc_valid`, input, 1: lookup request this cycle. When low, there is no miss detection.
- `flush`, input, 1: invalidate all lines.
- `inst`, output, 32: instruction word for `pc`. Meaningful only when `pc_valid & ~cache_freeze`.
- `cache_freeze`, output, 1: stall request to the PC register and pipeline.
- `mem_req`, output, 1: refill read request, registered.
- `mem_addr`, output, 32: refill word address, registered, word-aligned.
- `mem_ack`, input, 1: single-cycle acknowledge. `mem_rdata` is valid in the same cycle.
- `mem_rdata`, input, 32: refill data.

## Operation
- Address split:
  - offset = `pc[2]`
  - index = `pc[2+IDX_W:3]`
  - tag = `pc[31:3+IDX_W]`
- Storage per line: valid bit, tag, and two data words.
- Hit = `pc_valid & valid[index] & (tag_store[index]==tag)`. On a hit, `inst = data[index][offset]`.
- Miss = `pc_valid & ~hit`.
- `cache_freeze = (state != IDLE) | (state == IDLE & miss)`. It is combinational.
- FSM states: IDLE, FILL0, FILL1.
  - IDLE, on a miss: latch `{tag, index}` as the miss line. Set `mem_addr = {tag, index, 3'b000}` and `mem_req = 1`. Go to FILL0.
  - FILL0, on `mem_ack`: capture `mem_rdata` into buffer word 0. Set `mem_addr` to the miss line plus 4 and keep `mem_req = 1`. Go to FILL1.
  - FILL1, on `mem_ack`: write buffer word 0 and `mem_rdata` into the line. Write the tag and set valid (unless a flush is pending). Drop `mem_req` and go to IDLE.
  - Without `mem_ack`, FILL0 and FILL1 hold, and `mem_req`/`mem_addr` stay stable.
- Fills always use the latched miss address. Changes on `pc` during a fill do not affect the fill. After the fill, IDLE re-evaluates the current `pc`.
- `mem_ack` in IDLE is ignored.
- Flush in IDLE: all valid bits clear at the edge. A miss in that same cycle still starts a fill.
- Flush in FILL0/FILL1: set a flush-pending flag. The fill completes, then at the FILL1 completion edge all valid bits clear, including the just-filled line, and the flag clears.
- Reset:
  - state = IDLE, all valid bits = 0, flush-pending = 0.
  - `mem_req = 0`, `mem_addr = 0`, fill buffer = 0.
  - `cache_freeze` follows the equation above, so it is 1 if `pc_valid` is high after reset.
  - Reset mid-fill abandons the request immediately. Memory must tolerate a dropped `mem_req`.
  - Data and tag arrays are not reset.

## Timing
- Hit: zero latency. `inst` is valid in the same cycle as `pc`.
- Miss, minimum: frozen for 3 cycles (IDLE detect, FILL0, FILL1) when `mem_ack` arrives in the first cycle of each `mem_req`. The 4th cycle is a hit with `cache_freeze = 0`.
- Miss, general: frozen for `1 + (FILL0 wait + 1) + (FILL1 wait + 1)` cycles.
- `mem_req` rises one edge after the miss is detected and falls on the edge after the FILL1 ack. `mem_addr` changes only on the edges that enter FILL0 or FILL1.

## Structure
- Shared package `inst_cache_pkg`:
  - FSM state enum {IDLE, FILL0, FILL1}
  - `WORD_W = 32`
  - address field width functions derived from `LINES`
- Data and tag arrays live in one sub-module, `inst_cache_array`: one read port (combinational), one write port (whole line), and a valid-bit vector with clear-all.
- The FSM and the hit logic live in `inst_cache`.

## Test plan
- Cold miss: `LINES=32`, `pc=0x0`, ack in the first cycle. Expect `mem_addr` 0x0 then 0x4, freeze for 3 cycles, then `inst` equals memory word 0. Then `pc=0x4` hits with freeze 0 and no `mem_req`.
- Conflict: fill 0x0, then `pc=0x100` (same index 0, different tag). Expect a miss with refill at 0x100/0x104. A later `pc=0x0` misses again.
- Slow memory: ack delayed 5 cycles per word. Expect `mem_req`/`mem_addr` stable throughout, freeze for 13 cycles, and correct data.
- Flush mid-fill: assert `flush` in FILL0 for `pc=0x20`. Expect the fill to complete, then `pc=0x20` misses again in the following cycle.
- Reset mid-fill: assert `rst` in FILL1. Expect `mem_req=0` immediately, state IDLE, and all lines invalid: a previously filled 0x0 now misses.
- Idle: `pc_valid=0` with any `pc` gives `cache_freeze=0` and `mem_req=0`. `mem_ack` pulses in IDLE have no effect.
